// File: rtl/timebase_ctrl.sv
// Run/pause scheduler for the divide-by-N timebase: owns the divide counter,
// sequences it from start/stop/manual-step and takes new divisors on period boundaries.
module timebase_ctrl #(
  parameter int               CNT_W   = 28,
  parameter logic [CNT_W-1:0] DIVISOR = 28'd50000000
) (
  input  logic             clock_high_hz,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             sec_in,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_divisor,
  output logic             cfg_ready,
  output logic             tick,
  output logic             half_tick,
  output logic             clock_1hz,
  output logic             running,
  output logic [15:0]      tick_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'b10};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_q, tick_d;
  logic             half_q, half_d;
  logic             clk_q, clk_d;
  logic             run_q, run_d;
  logic [15:0]      tcnt_q, tcnt_d;
  logic             sec_q;

  logic             counting_s;
  logic             wrap_s;
  logic             step_s;
  logic             apply_s;
  logic             clear_s;
  logic [CNT_W-1:0] half_s;

  // State transitions; stop wins over start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!stop && start) state_d = RUN;
        else                state_d = IDLE;
      end
      RUN: begin
        if (stop) state_d = PAUSE;
        else      state_d = RUN;
      end
      PAUSE: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
        else            state_d = PAUSE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter, divisor hand-over and output next-state.
  always_comb begin
    // The counter only advances while the block stays in RUN across the edge.
    counting_s = (state_q == RUN) && (state_d == RUN);
    wrap_s     = counting_s && (cnt_q == (div_q - CNT_ONE));
    // A manual step is taken only while parked, never on a state change.
    step_s     = sec_in && !sec_q && (state_q != RUN) && (state_d == state_q);
    apply_s    = pend_vld_q && ((state_q != RUN) || wrap_s);
    clear_s    = (state_q == PAUSE) && (state_d == IDLE);

    if (apply_s) div_d = pend_div_q;
    else         div_d = div_q;
    half_s = div_d >> 1;

    if (apply_s || wrap_s)                        cnt_d = CNT_ZERO;
    else if (counting_s)                          cnt_d = cnt_q + CNT_ONE;
    else if ((state_q == IDLE) || (state_d == IDLE)) cnt_d = CNT_ZERO;
    else                                          cnt_d = cnt_q;

    pend_vld_d = pend_vld_q;
    pend_div_d = pend_div_q;
    if (apply_s) begin
      pend_vld_d = 1'b0;
    end else if (cfg_valid && !pend_vld_q) begin
      pend_vld_d = 1'b1;
      pend_div_d = (cfg_divisor < CNT_TWO) ? CNT_TWO : cfg_divisor;
    end else begin
      pend_vld_d = pend_vld_q;
    end

    tick_d = wrap_s || step_s;
    half_d = counting_s && !wrap_s && (cnt_d == half_s);

    if (clear_s)     tcnt_d = 16'd0;
    else if (tick_d) tcnt_d = tcnt_q + 16'd1;
    else             tcnt_d = tcnt_q;

    case (state_d)
      RUN:     clk_d = (cnt_d < half_s);
      PAUSE:   clk_d = clk_q;
      IDLE:    clk_d = 1'b0;
      default: clk_d = 1'b0;
    endcase

    run_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clock_high_hz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      div_q      <= DIVISOR;
      pend_div_q <= CNT_ZERO;
      pend_vld_q <= 1'b0;
      tick_q     <= 1'b0;
      half_q     <= 1'b0;
      clk_q      <= 1'b0;
      run_q      <= 1'b0;
      tcnt_q     <= 16'd0;
      sec_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
      half_q     <= half_d;
      clk_q      <= clk_d;
      run_q      <= run_d;
      tcnt_q     <= tcnt_d;
      sec_q      <= sec_in;
    end
  end

  assign cfg_ready  = ~pend_vld_q;
  assign tick       = tick_q;
  assign half_tick  = half_q;
  assign clock_1hz  = clk_q;
  assign running    = run_q;
  assign tick_count = tcnt_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Directed bench for timebase_ctrl with a short period (10) so every corner is reachable.
module tb_timebase_ctrl;

  localparam int W = 28;

  logic         clk         = 1'b0;
  logic         reset       = 1'b1;
  logic         start       = 1'b0;
  logic         stop        = 1'b0;
  logic         sec_in      = 1'b0;
  logic         cfg_valid   = 1'b0;
  logic [W-1:0] cfg_divisor = 28'd0;
  logic         cfg_ready;
  logic         tick;
  logic         half_tick;
  logic         clock_1hz;
  logic         running;
  logic [15:0]  tick_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        st;
    logic        sp;
    logic        e_tick;
    logic        e_half;
    logic        e_clk;
    logic        e_run;
    logic        e_rdy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[34];

  timebase_ctrl #(.CNT_W(W), .DIVISOR(28'd10)) dut (
    .clock_high_hz(clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .sec_in       (sec_in),
    .cfg_valid    (cfg_valid),
    .cfg_divisor  (cfg_divisor),
    .cfg_ready    (cfg_ready),
    .tick         (tick),
    .half_tick    (half_tick),
    .clock_1hz    (clock_1hz),
    .running      (running),
    .tick_count   (tick_count)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, settle past it.
  task automatic cyc(input logic s, input logic p, input logic q, input logic v,
                     input logic [W-1:0] d);
    start = s; stop = p; sec_in = q; cfg_valid = v; cfg_divisor = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic et, input logic eh, input logic ec,
                            input logic er, input logic ey, input logic [15:0] en);
    logic [20:0] act;
    logic [20:0] exp;
    act = {tick, half_tick, clock_1hz, running, cfg_ready, tick_count};
    exp = {et, eh, ec, er, ey, en};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got tick=%b half=%b clk=%b run=%b rdy=%b cnt=%0d, want tick=%b half=%b clk=%b run=%b rdy=%b cnt=%0d",
               nm, tick, half_tick, clock_1hz, running, cfg_ready, tick_count,
               et, eh, ec, er, ey, en);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; sec_in = 1'b0; cfg_valid = 1'b0; cfg_divisor = 28'd0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int          pulses;
    logic [8:0]  seq;
    int          m;

    // Free-running period of 10 from IDLE, then pause and clear.
    for (int k = 0; k < 32; k++) begin
      vt[k].st     = (k == 0);
      vt[k].sp     = 1'b0;
      vt[k].e_tick = (k > 0) && (k % 10 == 0);
      vt[k].e_half = (k % 10 == 5);
      vt[k].e_clk  = (k % 10 < 5);
      vt[k].e_run  = 1'b1;
      vt[k].e_rdy  = 1'b1;
      vt[k].e_cnt  = 16'(k / 10);
    end
    vt[32].st = 1'b0; vt[32].sp = 1'b1; vt[32].e_tick = 1'b0; vt[32].e_half = 1'b0;
    vt[32].e_clk = 1'b1; vt[32].e_run = 1'b0; vt[32].e_rdy = 1'b1; vt[32].e_cnt = 16'd3;
    vt[33].st = 1'b0; vt[33].sp = 1'b1; vt[33].e_tick = 1'b0; vt[33].e_half = 1'b0;
    vt[33].e_clk = 1'b0; vt[33].e_run = 1'b0; vt[33].e_rdy = 1'b1; vt[33].e_cnt = 16'd0;

    #12;
    expect_out("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 34; k++) begin
      cyc(vt[k].st, vt[k].sp, 1'b0, 1'b0, 28'd0);
      expect_out($sformatf("vec_%0d", k), vt[k].e_tick, vt[k].e_half, vt[k].e_clk,
                 vt[k].e_run, vt[k].e_rdy, vt[k].e_cnt);
    end

    // Pause at counter 3, resume: tick 7 cycles later.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 28'd0);
    for (int i = 1; i <= 13; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 28'd0);
    expect_out("pre_pause", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 28'd0);
    expect_out("pause_enter", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 28'd0);
      expect_out($sformatf("pause_hold_%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 28'd0);
    expect_out("resume", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 28'd0);
      expect_out($sformatf("resume_%0d", i), (i == 7), (i == 2), (i < 2) || (i == 7),
                 1'b1, 1'b1, (i == 7) ? 16'd2 : 16'd1);
    end

    // Manual steps while paused; counter must stay at 0.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 28'd0);
    expect_out("pause_for_step", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
    seq    = 9'b010101111;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, seq[i], 1'b0, 28'd0);
      if (tick) pulses++;
    end
    chk("step_pulses", pulses, 3);
    chk("step_count", int'(tick_count), 5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 28'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b0, i[0], 1'b0, 28'd0);
      chk($sformatf("run_sec_tick_%0d", i), int'(tick), (i == 10) ? 1 : 0);
    end
    chk("run_sec_count", int'(tick_count), 6);

    // Divisor 4 offered at counter 3; second offer while pending is refused.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 28'd0);
    for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 28'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 28'd4);
    expect_out("cfg_accept", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    for (int k = 5; k <= 22; k++) begin
      cyc(1'b0, 1'b0, 1'b0, (k <= 6), 28'd7);
      if (k < 10) begin
        expect_out($sformatf("cfg_k%0d", k), 1'b0, (k == 5), (k < 5), 1'b1, 1'b0, 16'd0);
      end else begin
        m = (k - 10) % 4;
        expect_out($sformatf("cfg_k%0d", k), (m == 0), (m == 2), (m < 2), 1'b1, 1'b1,
                   16'(1 + (k - 10) / 4));
      end
    end

    // Divisor 0 clamps to 2: square clock toggles every cycle.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 28'd0);
    expect_out("clamp_pending", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 28'd0);
    expect_out("clamp_applied", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 28'd0);
    expect_out("div2_start", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 28'd0);
      expect_out($sformatf("div2_%0d", i), (i % 2 == 0), (i % 2 == 1), (i % 2 == 0),
                 1'b1, 1'b1, 16'(i / 2));
    end

    // start and stop together in RUN pause; stop in PAUSE clears.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 28'd0);
    expect_out("both_pause", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 28'd0);
    expect_out("stop_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);

    // Reset mid-period with a divisor pending restores the default period.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 28'd0);
    expect_out("mid_start", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 28'd6);
    expect_out("mid_pending", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    cfg_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 28'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 28'd0);
      expect_out($sformatf("post_reset_%0d", i), (i == 10), (i == 5), (i % 10 < 5),
                 1'b1, 1'b1, 16'(i / 10));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
